// File: rtl/banked_reg_file.sv
// banked_reg_file: multi-bank register file for the 8-bit datapath.
// Holds BANKS register sets selected by ActiveBank. Address 0 (the accumulator)
// is a single physical register shared by every bank. It is stored as
// mem[0][0], and the matching pending bit is pend[0][0]. Entry 0 of every
// other bank is never selected.
module banked_reg_file #(
    parameter int W       = 8,
    parameter int D       = 3,
    parameter int BANKS   = 2,
    parameter int IMM_REG = 2**D - 1,
    parameter bit BYPASS  = 1'b1,
    localparam int BW     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WriteEn,
    input  logic          Immediate,
    input  logic [W-1:0]  ImmediateValue,
    input  logic [D-1:0]  Waddr,
    input  logic [W-1:0]  DataIn,
    input  logic [D-1:0]  RaddrA,
    input  logic [D-1:0]  RaddrB,
    output logic [W-1:0]  DataOutA,
    output logic [W-1:0]  DataOutB,
    output logic          ReadyA,
    output logic          ReadyB,
    input  logic          BankReq,
    input  logic [BW-1:0] BankTarget,
    output logic [BW-1:0] ActiveBank,
    output logic          BankErr,
    input  logic          PendSet,
    input  logic [D-1:0]  PendAddr,
    output logic [W-1:0]  AccumulatorValue
);

    localparam int           NREG     = 2**D;
    localparam logic [D-1:0] IMM_ADDR = D'(IMM_REG);

    logic [W-1:0]    mem  [BANKS][NREG];
    logic [NREG-1:0] pend [BANKS];

    logic [D-1:0]  wr_addr;
    logic [W-1:0]  wr_data;
    logic [BW-1:0] wr_bank;
    logic [BW-1:0] pend_bank;
    logic [BW-1:0] bank_a;
    logic [BW-1:0] bank_b;
    logic          bank_bad;

    // Map an address to its physical bank: address 0 always lives in bank 0.
    function automatic logic [BW-1:0] phys_bank(input logic [D-1:0] addr,
                                                input logic [BW-1:0] active);
        return (addr == '0) ? '0 : active;
    endfunction

    // Resolve the effective write port and the physical banks for each access.
    always_comb begin
        wr_addr   = Immediate ? IMM_ADDR : Waddr;
        wr_data   = Immediate ? ImmediateValue : DataIn;
        wr_bank   = phys_bank(wr_addr, ActiveBank);
        pend_bank = phys_bank(PendAddr, ActiveBank);
        bank_a    = phys_bank(RaddrA, ActiveBank);
        bank_b    = phys_bank(RaddrB, ActiveBank);
        bank_bad  = {1'b0, BankTarget} >= (BW+1)'(BANKS);
    end

    // Read port A: stored value from the active bank, optionally forwarded.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        DataOutA = mem[bank_a][RaddrA];
        ReadyA   = !pend[bank_a][RaddrA];
        if (BYPASS && WriteEn && (wr_addr == RaddrA)) begin
            DataOutA = wr_data;
            if (!(PendSet && (PendAddr == RaddrA)))
                ReadyA = 1'b1;
        end
    end

    // Read port B: same behaviour as port A.
    always_comb begin
        DataOutB = mem[bank_b][RaddrB];
        ReadyB   = !pend[bank_b][RaddrB];
        if (BYPASS && WriteEn && (wr_addr == RaddrB)) begin
            DataOutB = wr_data;
            if (!(PendSet && (PendAddr == RaddrB)))
                ReadyB = 1'b1;
        end
    end

    assign AccumulatorValue = mem[0][0];

    // Register storage and pending scoreboard.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the storage array is cleared on reset on purpose, because every register must read 0 afterwards, so it maps to flops rather than RAM.
            for (int b = 0; b < BANKS; b++) begin
                pend[b] <= '0;
                for (int r = 0; r < NREG; r++)
                    mem[b][r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; when the write and PendSet target the same bit, the later PendSet assignment wins.
            if (WriteEn) begin
                mem[wr_bank][wr_addr]  <= wr_data;
                pend[wr_bank][wr_addr] <= 1'b0;
            end
            if (PendSet)
                pend[pend_bank][PendAddr] <= 1'b1;
        end
    end

    // Bank pointer and the one-cycle error pulse for out-of-range targets.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ActiveBank <= '0;
            BankErr    <= 1'b0;
        end else begin
            BankErr <= 1'b0;
            if (BankReq) begin
                if (bank_bad)
                    BankErr <= 1'b1;
                else
                    ActiveBank <= BankTarget;
            end
        end
    end

endmodule
